// File: rtl/lc3b_types.sv
// Shared LC-3b types: ALU opcodes and the reservation station entry layout.
package lc3b_types;

    localparam int RS_TAG_W = 3;

    typedef enum logic [3:0] {
        alu_add,
        alu_and,
        alu_not,
        alu_pass,
        alu_sll,
        alu_srl,
        alu_sra,
        alu_sub,
        alu_or,
        alu_xor,
        alu_nand,
        alu_nor,
        alu_xnor
    } lc3b_aluop;

    typedef struct packed {
        logic                busy;
        lc3b_aluop           aluop;
        logic [15:0]         vj;
        logic [15:0]         vk;
        logic                qj_valid;
        logic [RS_TAG_W-1:0] qj;
        logic                qk_valid;
        logic [RS_TAG_W-1:0] qk;
        logic [RS_TAG_W-1:0] dest;
    } rs_entry_t;

endpackage

// File: rtl/alu_exec.sv
// Combinational LC-3b ALU: 16-bit logic/arith ops and 4-bit-amount shifts.
module alu_exec
    import lc3b_types::*;
(
    input  lc3b_aluop   aluop,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] f
);

    always_comb begin
        f = '0;
        unique case (aluop)
            alu_add:  f = a + b;
            alu_sub:  f = a - b;
            alu_and:  f = a & b;
            alu_nand: f = ~(a & b);
            alu_or:   f = a | b;
            alu_nor:  f = ~(a | b);
            alu_xor:  f = a ^ b;
            alu_xnor: f = ~(a ^ b);
            alu_not:  f = ~a;
            alu_pass: f = b;
            alu_sll:  f = a << b[3:0];
            alu_srl:  f = a >> b[3:0];
            alu_sra:  f = $signed(a) >>> b[3:0];
            default:  f = '0;
        endcase
    end

endmodule

// File: rtl/alu_res_station.sv
// ALU reservation station: tag-snooping operand capture, lowest-index issue
// into a single result register held until the CDB arbiter grants it.
module alu_res_station
    import lc3b_types::*;
#(
    parameter int N_ENTRIES = 4,
    parameter int TAG_W     = RS_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_valid,
    input  lc3b_aluop        disp_aluop,
    input  logic             disp_qj_valid,
    input  logic             disp_qk_valid,
    input  logic [TAG_W-1:0] disp_qj,
    input  logic [TAG_W-1:0] disp_qk,
    input  logic [15:0]      disp_vj,
    input  logic [15:0]      disp_vk,
    input  logic [TAG_W-1:0] disp_dest,
    output logic             full,
    input  logic             cdb_in_valid,
    input  logic [TAG_W-1:0] cdb_in_tag,
    input  logic [15:0]      cdb_in_data,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic [15:0]      res_data,
    input  logic             res_grant
);

    localparam int IDX_W = $clog2(N_ENTRIES);

    rs_entry_t        r_ent [N_ENTRIES];
    logic             r_res_valid;
    logic [TAG_W-1:0] r_res_tag;
    logic [15:0]      r_res_data;

    logic [N_ENTRIES-1:0] w_busy;
    logic [N_ENTRIES-1:0] w_ready;
    logic [IDX_W-1:0]     w_free_idx;
    logic [IDX_W-1:0]     w_rdy_idx;
    logic                 w_has_ready;
    logic                 w_issue;
    logic                 w_hit_j;
    logic                 w_hit_k;
    logic [15:0]          w_alu_f;
    rs_entry_t            w_new;

    always_comb begin
        w_free_idx  = '0;
        w_rdy_idx   = '0;
        w_has_ready = 1'b0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_busy[i]  = r_ent[i].busy;
            w_ready[i] = r_ent[i].busy & ~r_ent[i].qj_valid
                       & ~r_ent[i].qk_valid;
        end
        // Descending scan so the lowest index wins.
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!w_busy[i])
                w_free_idx = IDX_W'(i);
            if (w_ready[i]) begin
                w_rdy_idx   = IDX_W'(i);
                w_has_ready = 1'b1;
            end
        end
    end

    assign full    = &w_busy;
    assign w_issue = w_has_ready & (~r_res_valid | res_grant);

    assign w_hit_j = disp_qj_valid & cdb_in_valid & (cdb_in_tag == disp_qj);
    assign w_hit_k = disp_qk_valid & cdb_in_valid & (cdb_in_tag == disp_qk);

    always_comb begin
        w_new          = '0;
        w_new.busy     = 1'b1;
        w_new.aluop    = disp_aluop;
        w_new.vj       = w_hit_j ? cdb_in_data : disp_vj;
        w_new.vk       = w_hit_k ? cdb_in_data : disp_vk;
        w_new.qj_valid = disp_qj_valid & ~w_hit_j;
        w_new.qk_valid = disp_qk_valid & ~w_hit_k;
        w_new.qj       = disp_qj;
        w_new.qk       = disp_qk;
        w_new.dest     = disp_dest;
    end

    alu_exec u_alu (
        .aluop (r_ent[w_rdy_idx].aluop),
        .a     (r_ent[w_rdy_idx].vj),
        .b     (r_ent[w_rdy_idx].vk),
        .f     (w_alu_f)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ENTRIES; i++)
                r_ent[i] <= '0;
            r_res_valid <= 1'b0;
            r_res_tag   <= '0;
            r_res_data  <= '0;
        end else if (flush) begin
            for (int i = 0; i < N_ENTRIES; i++)
                r_ent[i].busy <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (r_ent[i].busy && r_ent[i].qj_valid && cdb_in_valid
                    && r_ent[i].qj == cdb_in_tag) begin
                    r_ent[i].vj       <= cdb_in_data;
                    r_ent[i].qj_valid <= 1'b0;
                end
                if (r_ent[i].busy && r_ent[i].qk_valid && cdb_in_valid
                    && r_ent[i].qk == cdb_in_tag) begin
                    r_ent[i].vk       <= cdb_in_data;
                    r_ent[i].qk_valid <= 1'b0;
                end
            end
            if (w_issue)
                r_ent[w_rdy_idx].busy <= 1'b0;
            if (disp_valid && !full)
                r_ent[w_free_idx] <= w_new;
            if (w_issue) begin
                r_res_valid <= 1'b1;
                r_res_tag   <= r_ent[w_rdy_idx].dest;
                r_res_data  <= w_alu_f;
            end else if (res_grant) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_tag   = r_res_tag;
    assign res_data  = r_res_data;

endmodule

// File: tb/tb_alu_res_station.sv
// Scenario bench for alu_res_station: reset, latency, snoop/bypass, full,
// grant stall, flush, async reset and back-to-back ALU op coverage.
module tb_alu_res_station;
    import lc3b_types::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        disp_valid;
    lc3b_aluop   disp_aluop;
    logic        disp_qj_valid;
    logic        disp_qk_valid;
    logic [2:0]  disp_qj;
    logic [2:0]  disp_qk;
    logic [15:0] disp_vj;
    logic [15:0] disp_vk;
    logic [2:0]  disp_dest;
    logic        full;
    logic        cdb_in_valid;
    logic [2:0]  cdb_in_tag;
    logic [15:0] cdb_in_data;
    logic        res_valid;
    logic [2:0]  res_tag;
    logic [15:0] res_data;
    logic        res_grant;

    typedef struct {
        logic [2:0]  tag;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    alu_res_station #(.N_ENTRIES(4), .TAG_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_aluop    (disp_aluop),
        .disp_qj_valid (disp_qj_valid),
        .disp_qk_valid (disp_qk_valid),
        .disp_qj       (disp_qj),
        .disp_qk       (disp_qk),
        .disp_vj       (disp_vj),
        .disp_vk       (disp_vk),
        .disp_dest     (disp_dest),
        .full          (full),
        .cdb_in_valid  (cdb_in_valid),
        .cdb_in_tag    (cdb_in_tag),
        .cdb_in_data   (cdb_in_data),
        .res_valid     (res_valid),
        .res_tag       (res_tag),
        .res_data      (res_data),
        .res_grant     (res_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] alu_ref(lc3b_aluop op, logic [15:0] a,
                                            logic [15:0] b);
        logic [31:0] ext;
        int          sh;
        sh  = int'(b[3:0]);
        ext = {{16{a[15]}}, a};
        case (op)
            alu_add:  return a + b;
            alu_sub:  return a + (~b) + 16'd1;
            alu_and:  return a & b;
            alu_nand: return ~(a & b);
            alu_or:   return a | b;
            alu_nor:  return ~(a | b);
            alu_xor:  return a ^ b;
            alu_xnor: return ~(a ^ b);
            alu_not:  return ~a;
            alu_pass: return b;
            alu_sll:  return 16'(a << sh);
            alu_srl:  return 16'(a >> sh);
            alu_sra:  return 16'(ext >> sh);
            default:  return 16'h0;
        endcase
    endfunction

    task automatic dispatch(lc3b_aluop op, logic qjv, logic [2:0] qj,
                            logic [15:0] vj, logic qkv, logic [2:0] qk,
                            logic [15:0] vk, logic [2:0] dest);
        disp_valid    = 1'b1;
        disp_aluop    = op;
        disp_qj_valid = qjv;
        disp_qj       = qj;
        disp_vj       = vj;
        disp_qk_valid = qkv;
        disp_qk       = qk;
        disp_vk       = vk;
        disp_dest     = dest;
        @(negedge clk);
        disp_valid    = 1'b0;
        disp_qj_valid = 1'b0;
        disp_qk_valid = 1'b0;
    endtask

    task automatic broadcast(logic [2:0] tag, logic [15:0] data);
        cdb_in_valid = 1'b1;
        cdb_in_tag   = tag;
        cdb_in_data  = data;
        @(negedge clk);
        cdb_in_valid = 1'b0;
    endtask

    task automatic drain(int budget);
        exp_t e;
        res_grant = 1'b1;
        for (int c = 0; c < budget && sb.size() > 0; c++) begin
            if (res_valid) begin
                e = sb.pop_front();
                checks++;
                if (res_tag !== e.tag || res_data !== e.data) begin
                    errors++;
                    $display("FAIL drain_result: got tag=%0d data=%h want tag=%0d data=%h",
                             res_tag, res_data, e.tag, e.data);
                end
            end
            @(negedge clk);
        end
        res_grant = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", res_valid); end
        checks++;
        if (res_tag !== 3'd0) begin errors++; $display("FAIL reset_tag: got %0d want 0", res_tag); end
        checks++;
        if (res_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", res_data); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        res_grant = 1'b0;
        dispatch(alu_add, 0, 0, 16'h0003, 0, 0, 16'h0004, 3'd2);
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got %b want 0", res_valid); end
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (res_valid !== 1'b1 || res_tag !== 3'd2 || res_data !== 16'h0007) begin
                errors++;
                $display("FAIL lat_hold: got v=%b tag=%0d data=%h want v=1 tag=2 data=0007",
                         res_valid, res_tag, res_data);
            end
            @(negedge clk);
        end
        res_grant = 1'b1;
        @(negedge clk);
        res_grant = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL lat_clear: got %b want 0", res_valid); end
    endtask

    task automatic test_snoop();
        dispatch(alu_sra, 0, 0, 16'h8000, 1, 3'd5, 16'h0000, 3'd3);
        repeat (2) @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL snoop_wait: got %b want 0", res_valid); end
        broadcast(3'd5, 16'h0003);
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL snoop_early: got %b want 0", res_valid); end
        sb.push_back('{3'd3, 16'hF000});
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL snoop_late: got %b want 1", res_valid); end
        drain(5);
        // Same tag on both operands: one broadcast satisfies j and k.
        dispatch(alu_add, 1, 3'd7, 16'h0000, 1, 3'd7, 16'h0000, 3'd6);
        broadcast(3'd7, 16'h0005);
        sb.push_back('{3'd6, 16'h000A});
        drain(6);
    endtask

    task automatic test_bypass();
        cdb_in_valid = 1'b1;
        cdb_in_tag   = 3'd4;
        cdb_in_data  = 16'h1234;
        dispatch(alu_pass, 1, 3'd4, 16'h0000, 0, 0, 16'h00FF, 3'd1);
        cdb_in_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL bypass_early: got %b want 0", res_valid); end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'h00FF) begin
            errors++;
            $display("FAIL bypass_pass: got v=%b data=%h want v=1 data=00ff", res_valid, res_data);
        end
        res_grant = 1'b1;
        @(negedge clk);
        res_grant = 1'b0;
        cdb_in_valid = 1'b1;
        cdb_in_tag   = 3'd6;
        cdb_in_data  = 16'h1000;
        dispatch(alu_add, 1, 3'd6, 16'h0000, 1, 3'd2, 16'h0000, 3'd5);
        cdb_in_tag   = 3'd2;
        cdb_in_data  = 16'h0001;
        @(negedge clk);
        cdb_in_valid = 1'b0;
        sb.push_back('{3'd5, 16'h1001});
        drain(6);
    endtask

    task automatic test_full();
        res_grant = 1'b0;
        for (int i = 0; i < 4; i++)
            dispatch(alu_add, 1, 3'd1, 16'h0000, 0, 0, 16'(i), 3'(i));
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL full_set: got %b want 1", full); end
        dispatch(alu_add, 1, 3'd1, 16'h0000, 0, 0, 16'h0009, 3'd7);
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL full_drop: got %b want 1", full); end
        broadcast(3'd1, 16'h0100);
        for (int i = 0; i < 4; i++)
            sb.push_back('{3'(i), 16'(16'h0100 + i)});
        drain(20);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (res_valid !== 1'b0 || full !== 1'b0) begin
                errors++;
                $display("FAIL full_after: got v=%b full=%b want v=0 full=0", res_valid, full);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        res_grant = 1'b0;
        dispatch(alu_and, 0, 0, 16'hF0F0, 0, 0, 16'h0FF0, 3'd5);
        dispatch(alu_or, 0, 0, 16'h1200, 0, 0, 16'h0034, 3'd6);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (res_valid !== 1'b1 || res_tag !== 3'd5 || res_data !== 16'h00F0) begin
                errors++;
                $display("FAIL stall_hold: got v=%b tag=%0d data=%h want v=1 tag=5 data=00f0",
                         res_valid, res_tag, res_data);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++)
            dispatch(alu_add, 1, 3'd2, 16'h0000, 0, 0, 16'h0000, 3'(i));
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL stall_full: got %b want 1", full); end
        res_grant = 1'b1;
        @(negedge clk);
        res_grant = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || res_tag !== 3'd6 || res_data !== 16'h1234) begin
            errors++;
            $display("FAIL stall_next: got v=%b tag=%0d data=%h want v=1 tag=6 data=1234",
                     res_valid, res_tag, res_data);
        end
        res_grant = 1'b1;
        @(negedge clk);
        res_grant = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL stall_empty: got %b want 0", res_valid); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_flush();
        res_grant = 1'b0;
        dispatch(alu_xnor, 0, 0, 16'h0000, 0, 0, 16'h0000, 3'd4);
        for (int i = 0; i < 3; i++)
            dispatch(alu_add, 1, 3'd3, 16'h0000, 0, 0, 16'h0000, 3'(i));
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'hFFFF || full !== 1'b0) begin
            errors++;
            $display("FAIL flush_pre: got v=%b data=%h full=%b want v=1 data=ffff full=0",
                     res_valid, res_data, full);
        end
        flush     = 1'b1;
        res_grant = 1'b1;
        dispatch(alu_add, 0, 0, 16'h0001, 0, 0, 16'h0001, 3'd7);
        flush     = 1'b0;
        res_grant = 1'b0;
        checks++;
        if (full !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: got full=%b v=%b want full=0 v=0", full, res_valid);
        end
        broadcast(3'd3, 16'h0000);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet: got %b want 0", res_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_rst_mid();
        res_grant = 1'b0;
        dispatch(alu_not, 0, 0, 16'h00FF, 0, 0, 16'h0000, 3'd7);
        dispatch(alu_add, 1, 3'd6, 16'h0000, 0, 0, 16'h0001, 3'd3);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'hFF00) begin
            errors++;
            $display("FAIL rst_pre: got v=%b data=%h want v=1 data=ff00", res_valid, res_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (res_valid !== 1'b0 || res_tag !== 3'd0 || res_data !== 16'h0 || full !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got v=%b tag=%0d data=%h full=%b want all 0",
                     res_valid, res_tag, res_data, full);
        end
        @(negedge clk);
        rst = 1'b0;
        broadcast(3'd6, 16'h0000);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_quiet: got %b want 0", res_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [15:0] a;
        logic [15:0] b;
        lc3b_aluop   op;
        res_grant = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (res_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: got unexpected tag=%0d data=%h", res_tag, res_data);
                end else begin
                    e = sb.pop_front();
                    if (res_tag !== e.tag || res_data !== e.data) begin
                        errors++;
                        $display("FAIL b2b_result: got tag=%0d data=%h want tag=%0d data=%h",
                                 res_tag, res_data, e.tag, e.data);
                    end
                end
            end
            if (i < 13) begin
                op            = lc3b_aluop'(i);
                a             = 16'($urandom);
                b             = 16'($urandom);
                disp_valid    = 1'b1;
                disp_aluop    = op;
                disp_qj_valid = 1'b0;
                disp_qk_valid = 1'b0;
                disp_vj       = a;
                disp_vk       = b;
                disp_dest     = 3'(i);
                sb.push_back('{3'(i), alu_ref(op, a, b)});
            end else begin
                disp_valid = 1'b0;
            end
            @(negedge clk);
        end
        res_grant = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_missing: %0d results outstanding, want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        disp_valid    = 1'b0;
        disp_aluop    = alu_add;
        disp_qj_valid = 1'b0;
        disp_qk_valid = 1'b0;
        disp_qj       = '0;
        disp_qk       = '0;
        disp_vj       = '0;
        disp_vk       = '0;
        disp_dest     = '0;
        cdb_in_valid  = 1'b0;
        cdb_in_tag    = '0;
        cdb_in_data   = '0;
        res_grant     = 1'b0;
        test_reset();
        test_latency();
        test_snoop();
        test_bypass();
        test_full();
        test_stall();
        test_flush();
        test_rst_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
